skew_wr_control: RTL and testbench
==================================

Name: skew_wr_control

Overview:
- Parametrised write-address/enable sequencer for the output-side memory of a WIDTH_HEIGHT-lane systolic array.
- Generates the diagonal (skewed) write-enable wavefront: lane i starts writing i cycles after lane 0 and writes num_rows consecutive rows.
- Each lane has its own address counter starting at base_addr.
- Adds run-length control, a start/busy/done handshake, programmable base address and configurable address width.

Parameters:
- WIDTH_HEIGHT, 16, number of lanes (array columns); at least 2.
- ADDR_WIDTH, 8, per-lane address width.
- LEN_WIDTH, 8, width of num_rows.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- num_rows  input  LEN_WIDTH  rows written per lane; sampled with start.
- base_addr  input  ADDR_WIDTH  first address of every lane; sampled with start.
- busy  output  1  high while a sequence is in progress.
- done  output  1  one-cycle completion pulse.
- wr_en  output  WIDTH_HEIGHT  per-lane write enable; bit i is lane i.
- wr_addr  output  WIDTH_HEIGHT*ADDR_WIDTH  per-lane address; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].

Behaviour:
- All outputs are registered.
- Reset value (reset=0, asynchronous): busy=0, done=0, wr_en=0, all wr_addr lanes=0, state=IDLE, internal counters=0.
- Reset mid-run aborts immediately. There is no partial completion and no done pulse.
- States: IDLE, RUN.
- IDLE + start + num_rows>0:
  - latch num_rows into len and base_addr into every lane counter;
  - clear step counter t to 0;
  - go to RUN.
- Outputs for cycle t of RUN reflect the registers updated at the edge that sampled start, so the first write cycle is the cycle after the start edge.
- RUN, cycle t (0 .. len+WIDTH_HEIGHT-2):
  - wr_en[i] = 1 iff i <= t < i+len;
  - wr_addr lane i = base_addr + (t-i) while wr_en[i] is high;
  - a lane counter increments only after a cycle in which its lane was enabled;
  - a lane that has not started shows base_addr;
  - a finished lane holds its last address + 1.
- busy = 1 for exactly len+WIDTH_HEIGHT-1 cycles, matching the cycles in which at least one wr_en bit may be high.
- Last RUN cycle (t = len+WIDTH_HEIGHT-2) -> next cycle:
  - IDLE; busy=0; wr_en=0; done=1 for one cycle;
  - every lane of wr_addr returns to 0.
- IDLE + start + num_rows==0: no writes, busy stays 0, done=1 in the following cycle.
- start while busy (RUN) is ignored. num_rows and base_addr are don't-care outside the start cycle.
- start in the same cycle done is high is accepted (IDLE), giving back-to-back runs with one idle cycle of wr_en=0.
- Address arithmetic is modulo 2^ADDR_WIDTH: wraps silently, no flag.
- t is wide enough for LEN_WIDTH max + WIDTH_HEIGHT; no overflow for any legal num_rows.
- Wavefront shape equals a left-shift-and-fill ramp up followed by a left-shift-with-zero drain. When num_rows=WIDTH_HEIGHT it reaches all-ones for exactly one cycle.

Optional Feature:
- Macro: SKEW_WR_STALL_EN.
- Defined:
  - extra input port stall (1 bit), after start in the port list;
  - while stall=1 in RUN: t and all lane counters freeze, wr_en is forced to 0, wr_addr holds, busy stays 1;
  - on stall=0 the sequence resumes exactly where it stopped;
  - stall in IDLE has no effect;
  - stall does not delay acceptance of start.
- Undefined: no stall port; the sequence never pauses. Timing is exactly as above.

Test Plan:
- WIDTH_HEIGHT=4, ADDR_WIDTH=8, num_rows=4, base_addr=0x10, start pulse:
  - wr_en = 0001,0011,0111,1111,1110,1100,1000 on consecutive cycles, then 0000 with done=1;
  - lane0 addrs 10,11,12,13; lane3 addrs 10..13 in cycles 3..6;
  - busy high for 7 cycles.
- num_rows=1, base_addr=0x00:
  - wr_en = 0001,0010,0100,1000; every lane writes address 0x00;
  - done in 5th cycle; busy high 4 cycles.
- num_rows=0 -> wr_en stays 0, busy stays 0, done pulses one cycle after start.
- base_addr=0xFE, num_rows=4 -> each lane writes FE,FF,00,01 (wrap); no other effect.
- start re-asserted during RUN, then reset driven low at t=2 -> start ignored, outputs all 0 asynchronously, no done; a new start after release runs normally.
- With SKEW_WR_STALL_EN, num_rows=4, stall high at t=2 for 3 cycles -> wr_en 0 for those 3 cycles; remaining pattern 0111,1111,... resumes unchanged; busy lasts 10 cycles.

Source files
------------

// File: rtl/skew_wr_control.sv
//------------------------------------------------------------------------------
// skew_wr_control : skewed per-lane write-enable/address sequencer for the
//                   output memory of a systolic array. Optional: SKEW_WR_STALL_EN
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module skew_wr_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
`ifdef SKEW_WR_STALL_EN
  input  logic                               stall,
`endif
  input  logic [LEN_WIDTH-1:0]               num_rows,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH_HEIGHT-1:0]            wr_en,
  output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] wr_addr
);

  localparam int TW = LEN_WIDTH + $clog2(WIDTH_HEIGHT) + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    len;
  logic [TW-1:0]           t;
  logic [WIDTH_HEIGHT-1:0] wave;
  logic [ADDR_WIDTH-1:0]   cnt [WIDTH_HEIGHT];

  logic                    hold;
  logic [TW-1:0]           t_next;
  logic [TW-1:0]           t_last;
  logic                    lane0_next;
  logic [WIDTH_HEIGHT-1:0] wave_next;

`ifdef SKEW_WR_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign t_next     = t + TW'(1);
  assign t_last     = TW'(len) + TW'(WIDTH_HEIGHT - 2);
  assign lane0_next = (t_next < TW'(len));
  // Lane i follows lane i-1 one step later, so the wavefront is a shift register.
  assign wave_next  = {wave[WIDTH_HEIGHT-2:0], lane0_next};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len   <= '0;
      t     <= '0;
      wave  <= '0;
      wr_en <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < WIDTH_HEIGHT; i++) cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_rows != '0) begin
              state <= RUN;
              len   <= num_rows;
              t     <= '0;
              wave  <= WIDTH_HEIGHT'(1);
              wr_en <= WIDTH_HEIGHT'(1);
              busy  <= 1'b1;
              for (int i = 0; i < WIDTH_HEIGHT; i++) cnt[i] <= base_addr;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Counters account for the write just completed, stalled or not.
          for (int i = 0; i < WIDTH_HEIGHT; i++)
            if (wr_en[i]) cnt[i] <= cnt[i] + ADDR_WIDTH'(1);
          if (hold) begin
            wr_en <= '0;
          end else if (t == t_last) begin
            state <= IDLE;
            len   <= '0;
            t     <= '0;
            wave  <= '0;
            wr_en <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            for (int i = 0; i < WIDTH_HEIGHT; i++) cnt[i] <= '0;
          end else begin
            t     <= t_next;
            wave  <= wave_next;
            wr_en <= wave_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH_HEIGHT; g++) begin : g_lane
    assign wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = cnt[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_skew_wr_control.sv
//------------------------------------------------------------------------------
// tb_skew_wr_control : table-driven scoreboard bench for skew_wr_control (4 lanes).
//------------------------------------------------------------------------------
`default_nettype none

module tb_skew_wr_control;
  localparam int WH = 4;
  localparam int AW = 8;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
`ifdef SKEW_WR_STALL_EN
  logic              stall = 1'b0;
`endif
  logic [LW-1:0]     num_rows = '0;
  logic [AW-1:0]     base_addr = '0;
  logic              busy;
  logic              done;
  logic [WH-1:0]     wr_en;
  logic [WH*AW-1:0]  wr_addr;

  skew_wr_control #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SKEW_WR_STALL_EN
    .stall(stall),
`endif
    .num_rows(num_rows),
    .base_addr(base_addr),
    .busy(busy),
    .done(done),
    .wr_en(wr_en),
    .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WH-1:0]    en;
    logic [WH*AW-1:0] addr;
    logic             busy;
    logic             done;
  } obs_t;

  typedef struct {
    int            n;
    logic [AW-1:0] base;
    int            busy_cyc;
    int            done_at;
  } vec_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: lane i writes during i <= t < i+n at base+(t-i).
  function automatic obs_t step_exp(int n, logic [AW-1:0] base, int t);
    obs_t o;
    logic [AW-1:0] a;
    o.en = '0; o.addr = '0; o.busy = 1'b1; o.done = 1'b0;
    for (int i = 0; i < WH; i++) begin
      if (t < i) a = base;
      else if (t < i + n) begin a = base + AW'(t - i); o.en[i] = 1'b1; end
      else a = base + AW'(n);
      o.addr[i*AW +: AW] = a;
    end
    return o;
  endfunction

  function automatic obs_t idle_exp(logic d);
    obs_t o;
    o.en = '0; o.addr = '0; o.busy = 1'b0; o.done = d;
    return o;
  endfunction

  task automatic check(string name, obs_t e);
    n_vec++;
    if (wr_en !== e.en || wr_addr !== e.addr || busy !== e.busy || done !== e.done) begin
      n_err++;
      $display("FAIL %s: got en=%b addr=%h busy=%b done=%b, want en=%b addr=%h busy=%b done=%b",
               name, wr_en, wr_addr, busy, done, e.en, e.addr, e.busy, e.done);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(string name);
    @(negedge clk);
    start = 1'b0;
    if (sb.size() > 0) check(name, sb.pop_front());
  endtask

  task automatic apply(int n, logic [AW-1:0] b);
    start = 1'b1;
    num_rows = LW'(n);
    base_addr = b;
    if (n > 0)
      for (int t = 0; t < n + WH - 1; t++) sb.push_back(step_exp(n, b, t));
    sb.push_back(idle_exp(1'b1));
  endtask

  task automatic run_vec(string name, vec_t v);
    int bc;
    int dat;
    bc = 0; dat = 0;
    apply(v.n, v.base);
    sb.push_back(idle_exp(1'b0));
    for (int k = 1; k <= 400 && sb.size() > 0; k++) begin
      tick(name);
      if (busy) bc++;
      if (done) dat = k;
    end
    check_int({name, "_busy_cycles"}, bc, v.busy_cyc);
    check_int({name, "_done_cycle"}, dat, v.done_at);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{n: 4,   base: 8'h10, busy_cyc: 7,   done_at: 8};
    tbl[1] = '{n: 1,   base: 8'h00, busy_cyc: 4,   done_at: 5};
    tbl[2] = '{n: 0,   base: 8'h00, busy_cyc: 0,   done_at: 1};
    tbl[3] = '{n: 4,   base: 8'hFE, busy_cyc: 7,   done_at: 8};
    tbl[4] = '{n: 2,   base: 8'h33, busy_cyc: 5,   done_at: 6};
    tbl[5] = '{n: 6,   base: 8'h80, busy_cyc: 9,   done_at: 10};
    tbl[6] = '{n: 255, base: 8'h05, busy_cyc: 258, done_at: 259};

    repeat (2) @(negedge clk);
    check("reset_state", idle_exp(1'b0));
    reset = 1'b1;

    for (int v = 0; v < 7; v++) run_vec($sformatf("vec%0d", v), tbl[v]);

    // Back-to-back: start accepted in the done cycle.
    apply(4, 8'h10);
    for (int k = 0; k < 20 && sb.size() > 1; k++) tick("b2b_first");
    tick("b2b_done");
    apply(2, 8'h20);
    sb.push_back(idle_exp(1'b0));
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick("b2b_second");

    // start during RUN is ignored, then asynchronous reset aborts at t=2.
    apply(4, 8'h10);
    tick("abort_t0");
    tick("abort_t1");
    start = 1'b1; num_rows = 8'd9; base_addr = 8'h77;
    tick("ignored_start_t2");
    #2 reset = 1'b0;
    #1 check("async_reset", idle_exp(1'b0));
    sb.delete();
    for (int k = 0; k < 3; k++) sb.push_back(idle_exp(1'b0));
    for (int k = 0; k < 3; k++) tick("no_done_after_abort");
    reset = 1'b1;
    run_vec("after_reset", tbl[0]);

`ifdef SKEW_WR_STALL_EN
    begin
      obs_t s;
      int bc;
      bc = 0;
      s = step_exp(4, 8'h40, 2);
      s.en = '0;
      start = 1'b1; num_rows = 8'd4; base_addr = 8'h40;
      sb.push_back(step_exp(4, 8'h40, 0));
      sb.push_back(step_exp(4, 8'h40, 1));
      for (int k = 0; k < 3; k++) sb.push_back(s);
      for (int t = 2; t < 7; t++) sb.push_back(step_exp(4, 8'h40, t));
      sb.push_back(idle_exp(1'b1));
      sb.push_back(idle_exp(1'b0));
      tick("stall"); if (busy) bc++;
      tick("stall"); if (busy) bc++;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin tick("stall"); if (busy) bc++; end
      stall = 1'b0;
      for (int k = 0; k < 20 && sb.size() > 0; k++) begin tick("stall"); if (busy) bc++; end
      check_int("stall_busy_cycles", bc, 10);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
